// File: rtl/bp_pkg.sv
// Shared definitions for the branch predictor: table sizing defaults and
// the 2-bit direction counter encodings.
package bp_pkg;

    localparam int BP_ENTRIES = 16;
    localparam int BP_IDX_W   = 4;

    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,
        CTR_WNT = 2'b01,
        CTR_WT  = 2'b10,
        CTR_ST  = 2'b11
    } ctr_e;

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch-side lookup, execute-side update and statistics signals of the
// branch predictor. The core drives lookups/updates (master); the predictor
// answers them (slave).
interface branch_predictor_if;
    import bp_pkg::*;

    logic [31:0] fetch_pc_i;
    logic        predict_hit_o;
    logic        predict_taken_o;
    logic [31:0] predict_target_o;

    logic        upd_valid_i;
    logic [31:0] upd_pc_i;
    logic        upd_taken_i;
    logic [31:0] upd_target_i;
    logic        upd_mispredict_i;

    logic [31:0] stat_branches_o;
    logic [31:0] stat_mispredicts_o;

    modport master (
        output fetch_pc_i, upd_valid_i, upd_pc_i, upd_taken_i,
               upd_target_i, upd_mispredict_i,
        input  predict_hit_o, predict_taken_o, predict_target_o,
               stat_branches_o, stat_mispredicts_o
    );

    modport slave (
        input  fetch_pc_i, upd_valid_i, upd_pc_i, upd_taken_i,
               upd_target_i, upd_mispredict_i,
        output predict_hit_o, predict_taken_o, predict_target_o,
               stat_branches_o, stat_mispredicts_o
    );

endinterface

// File: rtl/bp_sat_counter.sv
// Next-state of a 2-bit saturating direction counter: step towards
// strongly-taken on a taken branch, towards strongly-not-taken otherwise.
module bp_sat_counter
    import bp_pkg::*;
(
    input  ctr_e cnt_i,
    input  logic taken_i,
    output ctr_e cnt_o
);

    // Saturating increment/decrement selected by the resolved direction.
    always_comb begin
        cnt_o = cnt_i;
        unique case (cnt_i)
            CTR_SNT: cnt_o = taken_i ? CTR_WNT : CTR_SNT;
            CTR_WNT: cnt_o = taken_i ? CTR_WT  : CTR_SNT;
            CTR_WT:  cnt_o = taken_i ? CTR_ST  : CTR_WNT;
            CTR_ST:  cnt_o = taken_i ? CTR_ST  : CTR_WT;
            default: cnt_o = cnt_i;
        endcase
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with per-entry 2-bit direction counters. Lookups are
// combinational on the fetch PC; resolved branches update the table at the
// clock edge with no forwarding into same-cycle lookups.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int ENTRIES = BP_ENTRIES,
    parameter int IDX_W   = BP_IDX_W
) (
    input logic               clk,
    input logic               rst,
    branch_predictor_if.slave bp
);

    localparam int TAG_W = 32 - IDX_W - 2;

    logic             valid_q [ENTRIES];
    ctr_e             ctr_q   [ENTRIES];
    logic [TAG_W-1:0] tag_q   [ENTRIES];
    logic [31:0]      tgt_q   [ENTRIES];

    logic [31:0] stat_br_q, stat_br_d;
    logic [31:0] stat_mis_q, stat_mis_d;

    logic [IDX_W-1:0] f_idx, u_idx;
    logic [TAG_W-1:0] f_tag, u_tag;
    logic             f_hit, f_taken, u_hit;
    ctr_e             ctr_d;
    logic [3:0]       unused_pc_bits;

    // Byte offset within the instruction word never affects the prediction.
    assign unused_pc_bits = {bp.fetch_pc_i[1:0], bp.upd_pc_i[1:0]};

    assign f_idx = bp.fetch_pc_i[IDX_W+1:2];
    assign f_tag = bp.fetch_pc_i[31:IDX_W+2];
    assign u_idx = bp.upd_pc_i[IDX_W+1:2];
    assign u_tag = bp.upd_pc_i[31:IDX_W+2];

    // Zero-latency lookup from the registered table contents.
    always_comb begin
        f_hit                = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
        f_taken              = f_hit && ctr_q[f_idx][1];
        bp.predict_hit_o     = f_hit;
        bp.predict_taken_o   = f_taken;
        bp.predict_target_o  = f_taken ? tgt_q[f_idx] : bp.fetch_pc_i + 32'd4;
        bp.stat_branches_o   = stat_br_q;
        bp.stat_mispredicts_o = stat_mis_q;
    end

    assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

    bp_sat_counter u_sat_counter (
        .cnt_i   (ctr_q[u_idx]),
        .taken_i (bp.upd_taken_i),
        .cnt_o   (ctr_d)
    );

    // Saturating statistics next-state.
    always_comb begin
        stat_br_d  = stat_br_q;
        stat_mis_d = stat_mis_q;
        if (bp.upd_valid_i) begin
            if (stat_br_q != 32'hFFFF_FFFF) stat_br_d = stat_br_q + 32'd1;
            if (bp.upd_mispredict_i && (stat_mis_q != 32'hFFFF_FFFF))
                stat_mis_d = stat_mis_q + 32'd1;
        end
    end

    // Valid bits, counters and stats; reset wins over a same-cycle update.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= CTR_WNT;
            end
            stat_br_q  <= '0;
            stat_mis_q <= '0;
        end else begin
            stat_br_q  <= stat_br_d;
            stat_mis_q <= stat_mis_d;
            if (bp.upd_valid_i) begin
                if (u_hit) begin
                    ctr_q[u_idx] <= ctr_d;
                end else if (bp.upd_taken_i) begin
                    valid_q[u_idx] <= 1'b1;
                    ctr_q[u_idx]   <= CTR_WT;
                end
            end
        end
    end

    // Tag/target storage is unreset. A taken update either hits (tag already
    // equal) or allocates, so both fields can be written on every taken update.
    always_ff @(posedge clk) begin
        if (!rst && bp.upd_valid_i && bp.upd_taken_i) begin
            tag_q[u_idx] <= u_tag;
            tgt_q[u_idx] <= bp.upd_target_i;
        end
    end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter ENTRIES, default 16; number of BTB entries; must be a power of 2.
REQ-002 SHALL have parameter IDX_W, default 4; log2(ENTRIES).
REQ-003 SHALL have clk, input, 1; clock; all state updates on the rising edge.
REQ-004 SHALL have rst, input, 1; reset; synchronous, active-high.
REQ-005 SHALL have fetch_pc_i, input, 32; PC being fetched this cycle.
REQ-006 SHALL have predict_hit_o, output, 1; fetch_pc_i matches a valid entry.
REQ-007 SHALL have predict_taken_o, output, 1; predicted direction.
REQ-008 SHALL have predict_target_o, output, 32; predicted next PC.
REQ-009 SHALL have upd_valid_i, input, 1; a resolved branch/jump leaves execute this cycle.
REQ-010 SHALL have upd_pc_i, input, 32; PC of the resolved branch.
REQ-011 SHALL have upd_taken_i, input, 1; actual direction.
REQ-012 SHALL have upd_target_i, input, 32; actual target.
REQ-013 SHALL have upd_mispredict_i, input, 1; direction or target fix was required.
REQ-014 SHALL have stat_branches_o, output, 32; count of accepted updates.
REQ-015 SHALL have stat_mispredicts_o, output, 32; count of mispredicted updates.

Function
REQ-016 SHALL index the table with pc[IDX_W+1:2] and tag it with pc[31:IDX_W+2]; pc[1:0] is ignored.
REQ-017 SHALL store per entry: valid (1b), tag, target (32b), 2-bit saturating counter.
REQ-018 SHALL produce the lookup combinationally from fetch_pc_i: zero-cycle latency.
REQ-019 SHALL drive predict_hit_o = valid && tag match.
REQ-020 SHALL drive predict_taken_o = hit && counter[1].
REQ-021 SHALL drive predict_target_o = stored target when predict_taken_o=1, else fetch_pc_i+4 (32-bit wrap).
REQ-022 SHALL commit updates at the clock edge where upd_valid_i=1; they are visible to lookups from the next cycle.
REQ-023 SHALL give a lookup that shares an index with a same-cycle update the pre-update contents; there is no bypass.
REQ-024 SHALL handle update hit (valid && tag match) as: counter +1 saturating at 11 if taken, -1 saturating at 00 if not; target overwritten only when taken.
REQ-025 SHALL handle update miss with taken=1 as: allocate (overwrite) the entry with valid=1, new tag, target, counter=10.
REQ-026 SHALL handle update miss with taken=0 as: no table change.
REQ-027 SHALL, on each accepted update, increment stat_branches_o and, if upd_mispredict_i=1, increment stat_mispredicts_o; both saturate at 0xFFFFFFFF.
REQ-028 SHALL ignore all upd_* inputs when upd_valid_i=0.

Reset
REQ-029 SHALL, while rst=1, clear every valid bit, set every counter to 01 and zero both stat counters in one cycle.
REQ-030 SHALL give rst priority over a same-cycle update, which is then dropped.
REQ-031 SHALL make outputs immediately after reset read: hit=0, taken=0, target=fetch_pc_i+4, stats=0.
REQ-032 SHALL leave tag and target storage unreset; it is don't-care while valid=0.

Structure
REQ-033 SHALL place the counter encodings (SNT=00, WNT=01, WT=10, ST=11) and the default ENTRIES/IDX_W values in shared package bp_pkg.
REQ-034 SHALL implement the saturating counter next-state logic in a single sub-module, bp_sat_counter, instantiated once on the update path.

Verification
REQ-035 SHALL cover: after reset, fetch_pc_i=0x80000010 -> hit=0, taken=0, target=0x80000014.
REQ-036 SHALL cover: update pc=0x80000010 taken=1 target=0x80000100; next cycle lookup 0x80000010 -> hit=1, taken=1, target=0x80000100.
REQ-037 SHALL cover: two not-taken updates of that PC -> counter 10->01->00; lookup -> hit=1, taken=0, target=0x80000014; a third not-taken update keeps it at 00.
REQ-038 SHALL cover: alias pc=0x80000050 (same index) taken=1 target=0x80000200 -> 0x80000010 now misses; 0x80000050 hits with target 0x80000200.
REQ-039 SHALL cover: update and lookup of the same index in one cycle -> old prediction that cycle, new one the next.
REQ-040 SHALL cover: 5 updates with 2 mispredicts -> stats 5/2; rst asserted together with an update -> stats 0 and table invalid.
